// File: rtl/irq_defs.sv
// Shared definitions for the interrupt controller: bus register map,
// FSM state encodings and CTRL bit positions.
package irq_defs;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int GE_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index, bit 0 wins.
module irq_prio_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] index
);
    always_comb begin
        valid = |req;
        index = '0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) index = W'(i);
        end
    end
endmodule

// File: rtl/irq_controller.sv
// Interrupt controller for the single-cycle MIPS core: edge-detected pending
// latch, mask/GE gating, fixed priority, and a req/ack/iret handshake FSM.
module irq_controller
    import irq_defs::*;
#(
    parameter int N_SRC   = 8,
    parameter int CAUSE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src_irq,
    input  logic               kernel_mode,
    output logic               irq,
    input  logic               irq_ack,
    input  logic               iret,
    output logic [CAUSE_W-1:0] cause,
    input  logic               bus_wr,
    input  logic [1:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata
);
    irq_state_e         state, state_nxt;
    logic [CAUSE_W-1:0] sel, sel_nxt;
    logic               ge;
    logic [N_SRC-1:0]   mask, pending, pending_nxt, src_prev;
    logic [N_SRC-1:0]   rise, wr_clr, ack_clr, eligible;
    logic               enc_valid;
    logic [CAUSE_W-1:0] enc_idx;

    assign rise     = src_irq & ~src_prev;
    assign wr_clr   = (bus_wr && bus_addr == REG_PENDING) ? bus_wdata[N_SRC-1:0] : '0;
    assign eligible = (ge && !kernel_mode) ? (pending & mask) : '0;
    // Clears applied first so a same-cycle edge always survives.
    assign pending_nxt = (pending & ~wr_clr & ~ack_clr) | rise;
    assign cause = sel;

    irq_prio_enc #(.N(N_SRC), .W(CAUSE_W)) u_enc (
        .req  (eligible),
        .valid(enc_valid),
        .index(enc_idx)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ack_clr   = '0;
        case (state)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_nxt = ST_REQ;
                    sel_nxt   = enc_idx;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_nxt    = ST_SERVICE;
                    ack_clr[sel] = 1'b1;
                end else if (!pending[sel] || !mask[sel] || !ge || kernel_mode) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (iret) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            irq      <= 1'b0;
            sel      <= '0;
            ge       <= 1'b0;
            mask     <= '0;
            pending  <= '0;
            src_prev <= '1;
        end else begin
            state    <= state_nxt;
            irq      <= (state_nxt == ST_REQ);
            sel      <= sel_nxt;
            src_prev <= src_irq;
            pending  <= pending_nxt;
            if (bus_wr && bus_addr == REG_CTRL) ge <= bus_wdata[GE_BIT];
            if (bus_wr && bus_addr == REG_MASK) mask <= bus_wdata[N_SRC-1:0];
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            REG_CTRL:    bus_rdata[GE_BIT] = ge;
            REG_MASK:    bus_rdata = 32'(mask);
            REG_PENDING: bus_rdata = 32'(pending);
            default: begin
                bus_rdata[15:8] = 8'(sel);
                bus_rdata[3:2]  = state;
                bus_rdata[0]    = irq;
            end
        endcase
    end
endmodule

// File: tb/tb_irq_controller.sv
// Directed-vector bench for irq_controller with hand-computed expectations.
module tb_irq_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  src_irq;
    logic        kernel_mode, irq_ack, iret, bus_wr;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata, d;
    logic        irq;
    logic [2:0]  cause;
    int          total = 0;
    int          bad = 0;

    irq_controller #(.N_SRC(8), .CAUSE_W(3)) dut (
        .clk(clk), .reset(reset), .src_irq(src_irq), .kernel_mode(kernel_mode),
        .irq(irq), .irq_ack(irq_ack), .iret(iret), .cause(cause),
        .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        bus_wr = 1'b1; bus_addr = a; bus_wdata = v;
        tick();
        bus_wr = 1'b0; bus_wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus_addr = a;
        #1;
        v = bus_rdata;
    endtask

    task automatic pulse(input logic [7:0] m);
        src_irq = m;
        tick();
        src_irq = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic ret();
        iret = 1'b1; tick(); iret = 1'b0;
    endtask

    initial begin
        reset = 1'b1; src_irq = '0; kernel_mode = 1'b0; irq_ack = 1'b0; iret = 1'b0;
        bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
        tick(); tick();
        chk("rst_irq", 32'(irq), 0);
        chk("rst_cause", 32'(cause), 0);
        rd(2'd0, d); chk("rst_ctrl", d, 0);
        rd(2'd1, d); chk("rst_mask", d, 0);
        rd(2'd2, d); chk("rst_pend", d, 0);
        rd(2'd3, d); chk("rst_status", d, 0);
        tick();
        reset = 1'b0;
        tick();

        // Register width masking
        wr(2'd1, 32'hFFFF_FFFF); rd(2'd1, d); chk("mask_upper0", d, 32'hFF);
        wr(2'd0, 32'hFFFF_FFFF); rd(2'd0, d); chk("ctrl_upper0", d, 32'h1);

        // 1: single source, latency and ack
        pulse(8'h08);
        rd(2'd2, d); chk("t1_pend", d, 32'h08);
        chk("t1_irq_early", 32'(irq), 0);
        tick();
        chk("t1_irq", 32'(irq), 1);
        chk("t1_cause", 32'(cause), 3);
        ack();
        chk("t1_irq_ack", 32'(irq), 0);
        rd(2'd2, d); chk("t1_pend_clr", d, 0);
        rd(2'd3, d); chk("t1_status_svc", d, 32'h308);
        ret();
        rd(2'd3, d); chk("t1_status_idle", d, 32'h300);

        // 2: simultaneous sources, priority
        pulse(8'h24);
        tick();
        chk("t2_irq", 32'(irq), 1);
        chk("t2_cause_first", 32'(cause), 2);
        ack(); ret(); tick();
        chk("t2_irq2", 32'(irq), 1);
        chk("t2_cause_second", 32'(cause), 5);
        ack(); ret();

        // 3: no preemption
        pulse(8'h10); tick();
        chk("t3_cause4", 32'(cause), 4);
        pulse(8'h02); tick();
        chk("t3_irq_hold", 32'(irq), 1);
        chk("t3_cause_hold", 32'(cause), 4);
        rd(2'd2, d); chk("t3_pend", d, 32'h12);
        ack();
        rd(2'd2, d); chk("t3_pend_after", d, 32'h02);
        ret(); tick();
        chk("t3_cause1", 32'(cause), 1);
        chk("t3_irq1", 32'(irq), 1);
        ack(); ret();

        // 4: mask retraction, kernel mode blocking
        pulse(8'h40); tick();
        chk("t4_req", 32'(irq), 1);
        wr(2'd1, 32'hBF);
        tick();
        chk("t4_retract_irq", 32'(irq), 0);
        rd(2'd3, d); chk("t4_status_idle", d, 32'h600);
        rd(2'd2, d); chk("t4_pend_kept", d, 32'h40);
        wr(2'd2, 32'h40); wr(2'd1, 32'hFF);
        rd(2'd2, d); chk("t4_pend_w1c", d, 0);
        kernel_mode = 1'b1;
        pulse(8'h01); tick(); tick(); tick();
        chk("t4_kernel_noirq", 32'(irq), 0);
        rd(2'd2, d); chk("t4_kernel_pend", d, 32'h01);
        kernel_mode = 1'b0;
        tick();
        chk("t4_kernel_exit_irq", 32'(irq), 1);
        chk("t4_kernel_exit_cause", 32'(cause), 0);
        ack(); ret();

        // 5: set beats clear, ack ignored in IDLE
        wr(2'd0, 32'h0);
        pulse(8'h40); tick();
        src_irq = 8'h40; bus_wr = 1'b1; bus_addr = 2'd2; bus_wdata = 32'h40;
        tick();
        src_irq = '0; bus_wr = 1'b0; bus_wdata = '0;
        rd(2'd2, d); chk("t5_set_wins", d, 32'h40);
        wr(2'd2, 32'h40);
        rd(2'd2, d); chk("t5_plain_clr", d, 0);
        ack();
        rd(2'd3, d); chk("t5_ack_idle", d, 32'h000);
        wr(2'd0, 32'h1);

        // 6: async reset mid-REQ, held-high lines at release
        pulse(8'h04); tick();
        chk("t6_req", 32'(irq), 1);
        #2 reset = 1'b1;
        #1 chk("t6_async_irq", 32'(irq), 0);
        chk("t6_async_cause", 32'(cause), 0);
        src_irq = 8'h81;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        wr(2'd1, 32'hFF); wr(2'd0, 32'h1); tick();
        rd(2'd2, d); chk("t6_no_pend", d, 0);
        chk("t6_no_irq", 32'(irq), 0);
        src_irq = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
